// File: rtl/ball_renderer.sv
// Bouncing square renderer: moves a ball once per frame and paints ball/border/background.
// Latency: rgb, hsync_out, vsync_out are registered, exactly 1 clk behind the pixel inputs.
// Backpressure: none; the pixel stream is free-running and the ball only moves on frame ticks.
module ball_renderer #(
   parameter int H_LEN      = 9,
   parameter int V_LEN      = 9,
   parameter int H_DISPLAY  = 640,
   parameter int V_DISPLAY  = 480,
   parameter int BALL_SIZE  = 8,
   parameter int BALL_SPEED = 2,
   parameter int BALL_X0    = 100,
   parameter int BALL_Y0    = 200
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             display_on,
   input  logic [H_LEN:0]   hpos,
   input  logic [V_LEN:0]   vpos,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [2:0]       rgb,
   output logic [H_LEN:0]   ball_x,
   output logic [V_LEN:0]   ball_y,
   output logic [7:0]       bounce_count
);

   // Arithmetic is carried one bit wider than the coordinates so limits never wrap.
   localparam int HW = H_LEN + 2;
   localparam int VW = V_LEN + 2;

   localparam logic [H_LEN+1:0] X_MAX  = HW'(H_DISPLAY - BALL_SIZE);
   localparam logic [H_LEN+1:0] X_SPD  = HW'(BALL_SPEED);
   localparam logic [H_LEN+1:0] X_SIZE = HW'(BALL_SIZE);
   localparam logic [H_LEN+1:0] X_LAST = HW'(H_DISPLAY - 1);
   localparam logic [V_LEN+1:0] Y_MAX  = VW'(V_DISPLAY - BALL_SIZE);
   localparam logic [V_LEN+1:0] Y_SPD  = VW'(BALL_SPEED);
   localparam logic [V_LEN+1:0] Y_SIZE = VW'(BALL_SIZE);
   localparam logic [V_LEN+1:0] Y_LAST = VW'(V_DISPLAY - 1);

   logic [H_LEN:0]   ball_x_q, ball_x_d;
   logic [V_LEN:0]   ball_y_q, ball_y_d;
   logic             dx_q, dx_d, dy_q, dy_d;
   logic [7:0]       bounce_count_q, bounce_count_d;
   logic             vsync_d_q;
   // armed_q blocks a false tick when vsync is already high as reset releases
   logic             armed_q;
   logic [2:0]       rgb_q, rgb_d;
   logic             hsync_out_q, vsync_out_q;

   logic             tick;
   logic             bounce_x, bounce_y;
   logic [H_LEN+1:0] x_wide, x_sum, hpos_wide;
   logic [V_LEN+1:0] y_wide, y_sum, vpos_wide;
   logic [H_LEN:0]   x_dif;
   logic [V_LEN:0]   y_dif;
   logic             in_ball, border;

   assign tick = vsync & ~vsync_d_q & armed_q;

   // Per-frame ball motion with wall clamping and bounce counting
   always_comb begin
      x_wide   = {1'b0, ball_x_q};
      y_wide   = {1'b0, ball_y_q};
      x_sum    = x_wide + X_SPD;
      y_sum    = y_wide + Y_SPD;
      x_dif    = ball_x_q - X_SPD[H_LEN:0];
      y_dif    = ball_y_q - Y_SPD[V_LEN:0];
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dx_d     = dx_q;
      dy_d     = dy_q;
      bounce_x = 1'b0;
      bounce_y = 1'b0;
      if (tick && run) begin
         if (dx_q) begin
            if (x_sum >= X_MAX) begin
               ball_x_d = X_MAX[H_LEN:0];
               dx_d     = 1'b0;
               bounce_x = 1'b1;
            end else begin
               ball_x_d = x_sum[H_LEN:0];
            end
         end else begin
            if (x_wide <= X_SPD) begin
               ball_x_d = '0;
               dx_d     = 1'b1;
               bounce_x = 1'b1;
            end else begin
               ball_x_d = x_dif;
            end
         end
         if (dy_q) begin
            if (y_sum >= Y_MAX) begin
               ball_y_d = Y_MAX[V_LEN:0];
               dy_d     = 1'b0;
               bounce_y = 1'b1;
            end else begin
               ball_y_d = y_sum[V_LEN:0];
            end
         end else begin
            if (y_wide <= Y_SPD) begin
               ball_y_d = '0;
               dy_d     = 1'b1;
               bounce_y = 1'b1;
            end else begin
               ball_y_d = y_dif;
            end
         end
      end
      bounce_count_d = bounce_count_q + {7'd0, bounce_x} + {7'd0, bounce_y};
   end

   // Pixel classification against the registered ball position; ball wins over border
   always_comb begin
      hpos_wide = {1'b0, hpos};
      vpos_wide = {1'b0, vpos};
      in_ball   = display_on
                  && (hpos_wide >= x_wide) && (hpos_wide < x_wide + X_SIZE)
                  && (vpos_wide >= y_wide) && (vpos_wide < y_wide + Y_SIZE);
      border    = display_on
                  && ((hpos == '0) || (hpos_wide == X_LAST)
                   || (vpos == '0) || (vpos_wide == Y_LAST));
      rgb_d     = 3'b000;
      if (in_ball) begin
         rgb_d = 3'b111;
      end else if (border) begin
         rgb_d = 3'b010;
      end
   end

   // State and output registers, all cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ball_x_q       <= (H_LEN+1)'(BALL_X0);
         ball_y_q       <= (V_LEN+1)'(BALL_Y0);
         dx_q           <= 1'b1;
         dy_q           <= 1'b1;
         bounce_count_q <= 8'd0;
         vsync_d_q      <= 1'b0;
         armed_q        <= 1'b0;
         rgb_q          <= 3'b000;
         hsync_out_q    <= 1'b0;
         vsync_out_q    <= 1'b0;
      end else begin
         ball_x_q       <= ball_x_d;
         ball_y_q       <= ball_y_d;
         dx_q           <= dx_d;
         dy_q           <= dy_d;
         bounce_count_q <= bounce_count_d;
         vsync_d_q      <= vsync;
         armed_q        <= armed_q | ~vsync;
         rgb_q          <= rgb_d;
         hsync_out_q    <= hsync;
         vsync_out_q    <= vsync;
      end
   end

   assign ball_x       = ball_x_q;
   assign ball_y       = ball_y_q;
   assign bounce_count = bounce_count_q;
   assign rgb          = rgb_q;
   assign hsync_out    = hsync_out_q;
   assign vsync_out    = vsync_out_q;

endmodule

// File: tb/tb_ball_renderer.sv
// Directed bench for ball_renderer: a full-size instance for motion, rendering and reset,
// plus a 17x17-screen instance whose odd wall positions reach the corner-wrap case quickly.
module tb_ball_renderer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       run = 1'b1;
   logic       hsync = 1'b0;
   logic       vsync = 1'b0;
   logic       vsync_s = 1'b0;
   logic       display_on = 1'b0;
   logic [9:0] hpos = '0;
   logic [9:0] vpos = '0;

   logic       d_hsync_out, d_vsync_out, s_hsync_out, s_vsync_out;
   logic [2:0] d_rgb, s_rgb;
   logic [9:0] d_ball_x, d_ball_y, s_ball_x, s_ball_y;
   logic [7:0] d_bounce, s_bounce;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ball_renderer d (
      .clk(clk), .reset_n(reset_n), .run(run), .hsync(hsync), .vsync(vsync),
      .display_on(display_on), .hpos(hpos), .vpos(vpos),
      .hsync_out(d_hsync_out), .vsync_out(d_vsync_out), .rgb(d_rgb),
      .ball_x(d_ball_x), .ball_y(d_ball_y), .bounce_count(d_bounce)
   );

   ball_renderer #(.H_DISPLAY(17), .V_DISPLAY(17), .BALL_X0(5), .BALL_Y0(5)) s (
      .clk(clk), .reset_n(reset_n), .run(run), .hsync(hsync), .vsync(vsync_s),
      .display_on(display_on), .hpos(hpos), .vpos(vpos),
      .hsync_out(s_hsync_out), .vsync_out(s_vsync_out), .rgb(s_rgb),
      .ball_x(s_ball_x), .ball_y(s_ball_y), .bounce_count(s_bounce)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick_d(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) vsync = 1'b1;
         repeat (2) @(negedge clk);
         vsync = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   task automatic tick_s(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) vsync_s = 1'b1;
         repeat (2) @(negedge clk);
         vsync_s = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   // drive a pixel at a negedge, sample rgb 1 time unit after the following posedge
   task automatic pix(input logic on, input int h, input int v, input int exp, input string tag);
      @(negedge clk);
      display_on = on;
      hpos = 10'(h);
      vpos = 10'(v);
      @(posedge clk);
      #1 chk(tag, 32'(d_rgb), exp);
   endtask

   initial begin
      // reset values
      repeat (2) @(negedge clk);
      chk("rst_x", 32'(d_ball_x), 100);
      chk("rst_y", 32'(d_ball_y), 200);
      chk("rst_cnt", 32'(d_bounce), 0);
      chk("rst_rgb", 32'(d_rgb), 0);
      chk("rst_dx", 32'(d.dx_q), 1);
      chk("rst_dy", 32'(d.dy_q), 1);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // rendering with ball at (100,200)
      pix(1'b1, 100, 200, 7, "rgb_ball_tl");
      pix(1'b1, 107, 207, 7, "rgb_ball_br");
      pix(1'b1, 108, 200, 0, "rgb_right_of_ball");
      pix(1'b1, 100, 208, 0, "rgb_below_ball");
      pix(1'b1, 0, 300, 2, "rgb_border_left");
      pix(1'b1, 639, 100, 2, "rgb_border_right");
      pix(1'b1, 300, 479, 2, "rgb_border_bottom");
      pix(1'b0, 0, 300, 0, "rgb_blank");
      pix(1'b0, 100, 200, 0, "rgb_blank_ball");

      // sync delay of exactly one clock
      @(negedge clk) hsync = 1'b1;
      #1 chk("hs_not_early", 32'(d_hsync_out), 0);
      @(posedge clk) #1 chk("hs_rise", 32'(d_hsync_out), 1);
      @(negedge clk) hsync = 1'b0;
      @(posedge clk) #1 chk("hs_fall", 32'(d_hsync_out), 0);
      @(negedge clk) vsync = 1'b1;
      #1 chk("vs_not_early", 32'(d_vsync_out), 0);
      @(posedge clk) #1 chk("vs_rise", 32'(d_vsync_out), 1);
      @(negedge clk) vsync = 1'b0;
      @(posedge clk) #1 chk("vs_fall", 32'(d_vsync_out), 0);
      // that vsync pulse was frame tick 1
      chk("tick1_x", 32'(d_ball_x), 102);
      tick_d(2);
      chk("tick3_x", 32'(d_ball_x), 106);
      chk("tick3_y", 32'(d_ball_y), 206);
      chk("tick3_cnt", 32'(d_bounce), 0);
      chk("tick3_dx", 32'(d.dx_q), 1);
      chk("tick3_dy", 32'(d.dy_q), 1);

      // frozen while run=0
      run = 1'b0;
      tick_d(5);
      chk("frz_x", 32'(d_ball_x), 106);
      chk("frz_y", 32'(d_ball_y), 206);
      chk("frz_cnt", 32'(d_bounce), 0);
      chk("frz_dx", 32'(d.dx_q), 1);
      run = 1'b1;

      // bottom wall at tick 136 (y 470->472), then right wall at tick 266
      tick_d(262);
      chk("t265_x", 32'(d_ball_x), 630);
      chk("t265_cnt", 32'(d_bounce), 1);
      chk("t265_dy", 32'(d.dy_q), 0);
      tick_d(1);
      chk("t266_x", 32'(d_ball_x), 632);
      chk("t266_dx", 32'(d.dx_q), 0);
      chk("t266_cnt", 32'(d_bounce), 2);
      chk("t266_y", 32'(d_ball_y), 212);
      tick_d(1);
      chk("t267_x", 32'(d_ball_x), 630);
      chk("t267_y", 32'(d_ball_y), 210);
      chk("t267_cnt", 32'(d_bounce), 2);

      // small screen: corner hit every 5 ticks (+2); 127 corners by tick 632
      tick_s(2);
      chk("s_t2_x", 32'(s_ball_x), 9);
      chk("s_t2_cnt", 32'(s_bounce), 2);
      tick_s(634);
      chk("s_t636_x", 32'(s_ball_x), 1);
      chk("s_t636_y", 32'(s_ball_y), 1);
      chk("s_t636_dx", 32'(s.dx_q), 0);
      chk("s_t636_cnt", 32'(s_bounce), 254);
      tick_s(1);
      chk("s_wrap_x", 32'(s_ball_x), 0);
      chk("s_wrap_y", 32'(s_ball_y), 0);
      chk("s_wrap_dx", 32'(s.dx_q), 1);
      chk("s_wrap_dy", 32'(s.dy_q), 1);
      chk("s_wrap_cnt", 32'(s_bounce), 0);

      // asynchronous reset with vsync high; release must not tick
      @(negedge clk) vsync = 1'b1;
      hsync = 1'b1;
      #2 reset_n = 1'b0;
      #1 chk("arst_x", 32'(d_ball_x), 100);
      chk("arst_cnt", 32'(d_bounce), 0);
      chk("arst_hs", 32'(d_hsync_out), 0);
      chk("arst_dx", 32'(d.dx_q), 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rel_no_tick_x", 32'(d_ball_x), 100);
      vsync = 1'b0;
      repeat (2) @(negedge clk);
      vsync = 1'b1;
      repeat (2) @(negedge clk);
      chk("rel_tick_x", 32'(d_ball_x), 102);
      chk("rel_tick_y", 32'(d_ball_y), 202);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_renderer.md
BALL_RENDERER -- requirements
Module: ball_renderer

Interface
REQ-001 SHALL have parameters: H_LEN, 9, hpos MSB index (hpos width H_LEN+1); V_LEN, 9, vpos MSB index; H_DISPLAY, 640, visible width; V_DISPLAY, 480, visible height; BALL_SIZE, 8, ball edge in pixels; BALL_SPEED, 2, pixels moved per frame per axis; BALL_X0, 100, reset X; BALL_Y0, 200, reset Y.
REQ-002 SHALL have ports, one per line, in this order:
  clk  input  1  pixel clock, all logic on rising edge
  reset_n  input  1  asynchronous, active-low reset
  run  input  1  1 = ball moves each frame, 0 = position frozen
  hsync  input  1  horizontal sync from timing generator, active-high
  vsync  input  1  vertical sync from timing generator, active-high
  display_on  input  1  1 = hpos/vpos inside visible area
  hpos  input  H_LEN+1  current pixel column
  vpos  input  V_LEN+1  current pixel row
  hsync_out  output  1  hsync delayed to align with rgb
  vsync_out  output  1  vsync delayed to align with rgb
  rgb  output  3  pixel colour {b,g,r}
  ball_x  output  H_LEN+1  ball left edge
  ball_y  output  V_LEN+1  ball top edge
  bounce_count  output  8  wall bounces, modulo 256

Function
REQ-003 SHALL register vsync once (vsync_d); frame tick = vsync & ~vsync_d (0->1 edge), one cycle wide.
REQ-004 SHALL hold direction bits dx (1 = right), dy (1 = down); position and direction change only in the cycle following a frame tick with run=1.
REQ-005 X update, dx=1: if ball_x + BALL_SPEED >= H_DISPLAY-BALL_SIZE then ball_x <= H_DISPLAY-BALL_SIZE, dx <= 0, bounce; else ball_x <= ball_x + BALL_SPEED.
REQ-006 X update, dx=0: if ball_x <= BALL_SPEED then ball_x <= 0, dx <= 1, bounce; else ball_x <= ball_x - BALL_SPEED.
REQ-007 Y update SHALL mirror REQ-005/006 using V_DISPLAY, ball_y, dy.
REQ-008 Comparisons SHALL be evaluated one bit wider than the operand so no wrap occurs at the limits.
REQ-009 bounce_count SHALL add 1 per axis that bounces in a tick (corner hit = +2), wrapping 255->0 (254 + corner = 0).
REQ-010 run=0 on a frame tick SHALL leave ball_x, ball_y, dx, dy, bounce_count unchanged.
REQ-011 Pixel classification, combinational on inputs: in_ball = display_on & ball_x <= hpos < ball_x+BALL_SIZE & ball_y <= vpos < ball_y+BALL_SIZE; border = display_on & (hpos==0 | hpos==H_DISPLAY-1 | vpos==0 | vpos==V_DISPLAY-1).
REQ-012 rgb SHALL be registered, latency exactly 1 clk: in_ball -> 3'b111; else border -> 3'b010; else display_on -> 3'b000 background; display_on=0 -> 3'b000. Ball overrides border.
REQ-013 hsync_out, vsync_out SHALL be the inputs delayed exactly 1 clk, matching rgb latency.
REQ-014 Ball position used by REQ-011 SHALL be the registered ball_x/ball_y; since ticks fall in vertical blanking, no mid-frame tearing.

Reset
REQ-015 While reset_n=0, asynchronously: ball_x=BALL_X0, ball_y=BALL_Y0, dx=1, dy=1, bounce_count=0, vsync_d=0, rgb=0, hsync_out=0, vsync_out=0.
REQ-016 Release of reset_n SHALL not itself produce a frame tick; if vsync is already 1 at release, the first tick requires vsync to fall and rise again.
REQ-017 Reset asserted mid-frame or mid-update SHALL abort immediately to REQ-015 values; no partial update survives.

Verification
REQ-018 Reset, then 3 vsync pulses with run=1 -> ball_x=106, ball_y=206, bounce_count=0, dx=dy=1.
REQ-019 Preload ball_x=630, dx=1, tick -> ball_x=632, dx=0, bounce_count+1; next tick -> ball_x=630.
REQ-020 Preload ball_x=1, ball_y=1, dx=dy=0, bounce_count=254, tick -> ball_x=0, ball_y=0, dx=dy=1, bounce_count=0.
REQ-021 Ball at (100,200): drive hpos=100, vpos=200, display_on=1 -> rgb=111 next clk; hpos=108 -> 000; hpos=0, vpos=300 -> 010; display_on=0 -> 000; hsync_out/vsync_out track inputs with 1-clk delay.
REQ-022 run=0 across 5 ticks -> position, direction, count unchanged; vsync held high through reset release -> no update until next 0->1 edge.
